// File: rtl/sram_controller_if.sv
// Bus bundle between the MEM stage, the SRAM controller and the SRAM pins.
// slave: controller side; master: core/SRAM environment side.
interface sram_controller_if;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic [15:0] sram_dq_in;
   logic        sram_dq_oe;
   logic        sram_we_n;

   modport slave (
      input  wr_en, rd_en, address, write_data, sram_dq_in,
      output read_data, ready, sram_addr, sram_dq_out,
      output sram_dq_oe, sram_we_n
   );

   modport master (
      output wr_en, rd_en, address, write_data, sram_dq_in,
      input  read_data, ready, sram_addr, sram_dq_out,
      input  sram_dq_oe, sram_we_n
   );
endinterface

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage accesses into two 16-bit SRAM phases, stalling via ready.
// Optional macro SRAM_ADDR_OFFSET_EN: subtract 1024 from the byte address.
module sram_controller #(
   parameter int WAIT_CYCLES = 2
) (
   input logic              clk,
   input logic              rst,
   sram_controller_if.slave bus
);

   localparam int CW = $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RD_LO = 3'd1;
   localparam logic [2:0] RD_HI = 3'd2;
   localparam logic [2:0] WR_LO = 3'd3;
   localparam logic [2:0] WR_HI = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [16:0]   word_q, word_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   addr_eff;
   logic          last;
   logic          is_wr;
   logic          is_hi;
   logic          in_phase;
   logic          unused_addr;

`ifdef SRAM_ADDR_OFFSET_EN
   assign addr_eff = bus.address - 32'd1024;
`else
   assign addr_eff = bus.address;
`endif

   assign unused_addr = ^{addr_eff[31:19], addr_eff[1:0]};
   assign last        = (cnt_q == LAST);

   // Next-state, wait counter, request latching and read capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      word_d  = word_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.wr_en) begin
               word_d  = addr_eff[18:2];
               wdata_d = bus.write_data;
               state_d = WR_LO;
            end else if (bus.rd_en) begin
               word_d  = addr_eff[18:2];
               state_d = RD_LO;
            end
         end
         RD_LO: begin
            if (last) begin
               rdata_d[15:0] = bus.sram_dq_in;
               state_d       = RD_HI;
               cnt_d         = '0;
            end
         end
         RD_HI: begin
            if (last) begin
               rdata_d[31:16] = bus.sram_dq_in;
               state_d        = DONE;
               cnt_d          = '0;
            end
         end
         WR_LO: begin
            if (last) begin
               state_d = WR_HI;
               cnt_d   = '0;
            end
         end
         WR_HI: begin
            if (last) begin
               state_d = DONE;
               cnt_d   = '0;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // SRAM pin decode straight from state so reset releases the bus at once.
   always_comb begin
      is_wr    = (state_q == WR_LO) || (state_q == WR_HI);
      is_hi    = (state_q == RD_HI) || (state_q == WR_HI);
      in_phase = is_wr || (state_q == RD_LO) || (state_q == RD_HI);
      bus.sram_addr   = in_phase ? {word_q, is_hi} : '0;
      bus.sram_dq_oe  = is_wr;
      bus.sram_we_n   = ~is_wr;
      bus.sram_dq_out = '0;
      if (state_q == WR_LO) bus.sram_dq_out = wdata_q[15:0];
      if (state_q == WR_HI) bus.sram_dq_out = wdata_q[31:16];
      bus.read_data   = rdata_q;
      bus.ready       = ~(bus.rd_en | bus.wr_en) | (state_q == DONE);
   end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: W=2 instance with SRAM model, W=1 instance.
// Expected SRAM addresses follow SRAM_ADDR_OFFSET_EN when it is defined.
module tb_sram_controller;

   localparam int WA = 2;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   sram_controller_if ifa ();
   sram_controller_if ifb ();

   sram_controller #(.WAIT_CYCLES(WA)) dut_a (
      .clk(clk),
      .rst(rst),
      .bus(ifa)
   );

   sram_controller #(.WAIT_CYCLES(1)) dut_b (
      .clk(clk),
      .rst(rst),
      .bus(ifb)
   );

   logic [15:0] mem [0:262143];

   function automatic logic [16:0] word_of(input logic [31:0] a);
      logic [31:0] e;
      e = a;
`ifdef SRAM_ADDR_OFFSET_EN
      e = a - 32'd1024;
`endif
      return e[18:2];
   endfunction

   assign ifa.sram_dq_in = mem[ifa.sram_addr];
   assign ifb.sram_dq_in = 16'h1234;

   always @(posedge clk) begin
      if (rst) begin
         mem[{word_of(32'd0), 1'b0}]    <= 16'hBEEF;
         mem[{word_of(32'd0), 1'b1}]    <= 16'hDEAD;
         mem[{word_of(32'd1028), 1'b0}] <= 16'h1111;
         mem[{word_of(32'd1028), 1'b1}] <= 16'h2222;
      end else if (!ifa.sram_we_n) begin
         mem[ifa.sram_addr] <= ifa.sram_dq_out;
      end
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic acc(input logic wr, input logic rd,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd);
      logic [17:0] base;
      logic        hi;
      base = {word_of(a), 1'b0};
      @(posedge clk);
      #1;
      ifa.wr_en      = wr;
      ifa.rd_en      = rd;
      ifa.address    = a;
      ifa.write_data = d;
      @(negedge clk);
      chk("ready_c0", {31'd0, ifa.ready}, 32'd0);
      for (int c = 1; c <= 2 * WA + 1; c++) begin
         @(negedge clk);
         if (c <= 2 * WA) begin
            hi = (c > WA);
            chk("ready_ph", {31'd0, ifa.ready}, 32'd0);
            chk("addr_ph", {14'd0, ifa.sram_addr},
                {14'd0, base | {17'd0, hi}});
            chk("we_n_ph", {31'd0, ifa.sram_we_n}, {31'd0, ~wr});
            chk("oe_ph", {31'd0, ifa.sram_dq_oe}, {31'd0, wr});
            if (wr)
               chk("dq_out", {16'd0, ifa.sram_dq_out},
                   {16'd0, hi ? d[31:16] : d[15:0]});
         end else begin
            chk("ready_done", {31'd0, ifa.ready}, 32'd1);
            chk("we_n_done", {31'd0, ifa.sram_we_n}, 32'd1);
            chk("oe_done", {31'd0, ifa.sram_dq_oe}, 32'd0);
            chk("rdata_done", ifa.read_data, exp_rd);
         end
      end
   endtask

   task automatic drop_req();
      @(posedge clk);
      #1;
      ifa.wr_en = 1'b0;
      ifa.rd_en = 1'b0;
   endtask

   vec_t vt [5];

   initial begin
      logic [17:0] lo1028;
      checks = 0;
      errors = 0;
`ifdef SRAM_ADDR_OFFSET_EN
      lo1028 = 18'd2;
`else
      lo1028 = 18'd514;
`endif
      vt[0] = '{1'b0, 1'b1, 32'd0,  32'h0,        32'hDEADBEEF};
      vt[1] = '{1'b1, 1'b0, 32'd8,  32'h12345678, 32'hDEADBEEF};
      vt[2] = '{1'b0, 1'b1, 32'd8,  32'h0,        32'h12345678};
      vt[3] = '{1'b1, 1'b1, 32'd16, 32'hCAFEF00D, 32'h12345678};
      vt[4] = '{1'b0, 1'b1, 32'd16, 32'h0,        32'hCAFEF00D};

      rst = 1'b1;
      ifa.wr_en = 0; ifa.rd_en = 0; ifa.address = 0; ifa.write_data = 0;
      ifb.wr_en = 0; ifb.rd_en = 0; ifb.address = 0; ifb.write_data = 0;
      #1;
      chk("rst_rdata", ifa.read_data, 32'd0);
      chk("rst_addr", {14'd0, ifa.sram_addr}, 32'd0);
      chk("rst_dq", {16'd0, ifa.sram_dq_out}, 32'd0);
      chk("rst_oe", {31'd0, ifa.sram_dq_oe}, 32'd0);
      chk("rst_we_n", {31'd0, ifa.sram_we_n}, 32'd1);
      chk("rst_ready", {31'd0, ifa.ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 5; i++)
         acc(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].wdata, vt[i].exp_rd);
      drop_req();

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_ready", {31'd0, ifa.ready}, 32'd1);
         chk("idle_we_n", {31'd0, ifa.sram_we_n}, 32'd1);
         chk("idle_oe", {31'd0, ifa.sram_dq_oe}, 32'd0);
      end

      @(posedge clk);
      #1;
      ifa.rd_en = 1'b1;
      ifa.address = 32'd1028;
      @(negedge clk);
      @(negedge clk);
      chk("a1028_lo", {14'd0, ifa.sram_addr}, {14'd0, lo1028});
      repeat (2) @(negedge clk);
      chk("a1028_hi", {14'd0, ifa.sram_addr}, {14'd0, lo1028 + 18'd1});
      repeat (2) @(negedge clk);
      chk("a1028_rd", ifa.read_data, 32'h22221111);
      chk("a1028_rdy", {31'd0, ifa.ready}, 32'd1);
      drop_req();

      @(posedge clk);
      #1;
      ifa.wr_en = 1'b1;
      ifa.address = 32'd24;
      ifa.write_data = 32'hAAAA5555;
      repeat (3) @(posedge clk);
      #1;
      chk("mid_we_n", {31'd0, ifa.sram_we_n}, 32'd0);
      rst = 1'b1;
      #1;
      chk("arst_we_n", {31'd0, ifa.sram_we_n}, 32'd1);
      chk("arst_oe", {31'd0, ifa.sram_dq_oe}, 32'd0);
      chk("arst_rdata", ifa.read_data, 32'd0);
      chk("arst_addr", {14'd0, ifa.sram_addr}, 32'd0);
      ifa.wr_en = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("arst_ready", {31'd0, ifa.ready}, 32'd1);
      acc(1'b0, 1'b1, 32'd0, 32'd0, 32'hDEADBEEF);
      drop_req();

      @(posedge clk);
      #1;
      ifb.rd_en = 1'b1;
      ifb.address = 32'd4;
      @(negedge clk);
      chk("w1_c0", {31'd0, ifb.ready}, 32'd0);
      @(negedge clk);
      chk("w1_c1", {31'd0, ifb.ready}, 32'd0);
      chk("w1_addr_lo", {14'd0, ifb.sram_addr},
          {14'd0, word_of(32'd4), 1'b0});
      chk("w1_we_n", {31'd0, ifb.sram_we_n}, 32'd1);
      chk("w1_oe", {31'd0, ifb.sram_dq_oe}, 32'd0);
      chk("w1_dq", {16'd0, ifb.sram_dq_out}, 32'd0);
      @(negedge clk);
      chk("w1_c2", {31'd0, ifb.ready}, 32'd0);
      chk("w1_addr_hi", {14'd0, ifb.sram_addr},
          {14'd0, word_of(32'd4), 1'b1});
      @(negedge clk);
      chk("w1_c3", {31'd0, ifb.ready}, 32'd1);
      chk("w1_rdata", ifb.read_data, 32'h12341234);
      @(posedge clk);
      #1 ifb.rd_en = 1'b0;

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller that sequences 32-bit data-memory accesses from the MEM stage onto a 16-bit-wide external SRAM. It replaces the single-cycle data memory between EXE_PIPE and MEM_PIPE. It splits each word into two half-word SRAM transactions with programmable wait states. It drops `ready` to freeze the whole pipeline until the access completes.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: cycles each half-word phase is held on the SRAM bus; legal range 1–15.

Ports:
- `clk`  in  1: core clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `wr_en`  in  1: write request from the MEM stage (`mem_w_en_mem`).
- `rd_en`  in  1: read request from the MEM stage (`mem_r_en_mem`).
- `address`  in  32: byte address (`alu_res_mem`).
- `write_data`  in  32: store data (`val_rm_mem`).
- `read_data`  out  32: assembled load word.
- `ready`  out  1: 0 means freeze IF, ID, EXE and all pipe registers; 1 means advance.
- `sram_addr`  out  18: SRAM half-word address.
- `sram_dq_out`  out  16: write data driven to the SRAM.
- `sram_dq_in`  in  16: read data from the SRAM.
- `sram_dq_oe`  out  1: tri-state enable for `sram_dq_out`.
- `sram_we_n`  out  1: active-low SRAM write strobe.

## Operation
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- Wait counter: `$clog2(WAIT_CYCLES+1)` bits. It is cleared on every state entry and increments each cycle within a phase. A phase ends when the counter reaches WAIT_CYCLES-1.
- **IDLE:**
  - If `wr_en` is 1, latch `address` and `write_data`, then go to WR_LO.
  - Otherwise, if `rd_en` is 1, latch `address`, then go to RD_LO.
  - If `wr_en` and `rd_en` are both 1, the write wins. This combination is illegal from the core, but the behaviour is defined.
- **Address mapping:** word = latched byte address >> 2, truncated to 17 bits. `sram_addr` = {word[16:0], half}, where half is 0 in the *_LO states and 1 in the *_HI states.
- **RD_LO / RD_HI:**
  - Outputs: `sram_we_n`=1, `sram_dq_oe`=0.
  - On the last cycle of RD_LO, capture `sram_dq_in` into `read_data[15:0]`.
  - On the last cycle of RD_HI, capture `sram_dq_in` into `read_data[31:16]`.
- **WR_LO / WR_HI:**
  - Outputs: `sram_dq_oe`=1, `sram_we_n`=0.
  - `sram_dq_out` = latched data [15:0] in WR_LO and [31:16] in WR_HI.
- **Phase transitions:** RD_LO→RD_HI→DONE and WR_LO→WR_HI→DONE.
- **DONE:** lasts one cycle, then goes to IDLE. In DONE, `sram_we_n`=1 and `sram_dq_oe`=0.
- **`ready`** is combinational: `ready = ~(rd_en | wr_en) | (state == DONE)`.
  - Non-memory instructions never stall.
- **`read_data`** holds its value until the next read overwrites it; writes do not change it.
- **Request dropped mid-operation** (only possible after reset): the current transaction still runs to DONE.

## Timing
- Cycle numbering: cycle 0 is the first cycle a request is visible in IDLE. During cycle 0, `ready`=0.
- Phase schedule:
  - LO phase: cycles 1..W.
  - HI phase: cycles W+1..2W.
  - DONE: cycle 2W+1, with `ready`=1. The pipeline advances at the end of this cycle.
- Total stall is 2W+1 cycles per access. This is 5 cycles at the default W=2, making a 6-cycle access.
- `read_data` is valid from cycle 2W+1.
- A back-to-back request issued in the cycle after DONE is accepted in IDLE with no bubble. That next cycle is its cycle 0.
- Reset values:
  - State IDLE, counter 0.
  - `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1.
  - `ready` = ~(rd_en|wr_en).
- Reset mid-transaction aborts immediately. `sram_we_n` rises asynchronously, and a write may be left half-written; no recovery is attempted.

## Configuration
- `SRAM_ADDR_OFFSET_EN` defined: 1024 is subtracted from the latched byte address before the `>> 2`. This matches the lab memory map, where data memory starts at 1024.
- Not defined: the raw byte address is used.
- The subtraction is modulo 2^32; no range check is performed.

## Test plan
- **Read, W=2, SRAM model holds 0xBEEF at 0 and 0xDEAD at 1:**
  - Stimulus: `rd_en`=1, address=0 (macro off).
  - Required: `ready`=0 for cycles 0–4 and 1 in cycle 5; `read_data`=0xDEADBEEF; `sram_addr` is 0 in cycles 1–2 and 1 in cycles 3–4.
- **Write, W=2:**
  - Stimulus: `wr_en`=1, address=8, data=0x12345678.
  - Required: `sram_addr`=4 with dq=0x5678 and `sram_we_n`=0 in cycles 1–2; `sram_addr`=5 with dq=0x1234 in cycles 3–4; `ready`=1 in cycle 5; `read_data` unchanged.
- **Back-to-back write then read, same address:** the read returns the written word, with no idle cycle between the two DONE→IDLE→accept sequences.
- **Reset mid-write:**
  - Stimulus: assert `rst` in cycle 3.
  - Required: `sram_we_n`=1, `sram_dq_oe`=0 and `read_data`=0 with no clock edge; after reset the state is IDLE, and a new request completes normally.
- **Macro on:** a read at address 1028 drives `sram_addr` 2 and 3.
- **Boundary cases:**
  - `WAIT_CYCLES`=1: `ready` rises in cycle 3.
  - `rd_en`=`wr_en`=1: a write is performed.
  - Both requests deasserted: `ready`=1 and the SRAM bus stays idle.
